// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: opcodes, field layout,
// FSM states and the tuple-to-word encoder.
package instr_encode_loader_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_LW  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JCC = 4'd14;
    localparam logic [3:0] OP_ITYPE_LO = 4'd5;
    localparam logic [3:0] OP_ITYPE_HI = OP_SW;

    // Bit positions shared with the instruction decoder
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 4;
    localparam int RS_LSB  = 7;
    localparam int RT_LSB  = 10;
    localparam int SH_LSB  = 13;
    localparam int IMM_LSB = 10;
    localparam int ADR_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] shamt;
        logic [5:0] imm;
        logic [7:0] adr;
    } fields_t;

    function automatic logic is_itype(input logic [3:0] op);
        return (op >= OP_ITYPE_LO) && (op <= OP_ITYPE_HI);
    endfunction

    function automatic logic is_jtype(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JCC);
    endfunction

    function automatic logic [INSTR_W-1:0] encode_instr(input fields_t f);
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OPC_LSB +: 4] = f.opcode;
        if (is_jtype(f.opcode)) begin
            w[ADR_LSB +: 8] = f.adr;
        end else if (is_itype(f.opcode)) begin
            w[RD_LSB  +: 3] = f.rd;
            w[RS_LSB  +: 3] = f.rs;
            w[IMM_LSB +: 6] = f.imm;
        end else begin
            w[RD_LSB +: 3] = f.rd;
            w[RS_LSB +: 3] = f.rs;
            w[RT_LSB +: 3] = f.rt;
            w[SH_LSB +: 3] = f.shamt;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_encode_loader_sync_fifo.sv
// Synchronous FIFO, DEPTH entries; push ignored when full, pop ignored when empty.
// Output shows the head entry combinationally; no bypass from push to output.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are never observed while empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes field tuples into 16-bit words and streams them to instruction memory.
// Accept at edge N -> mem_we from cycle N+1; in_ready drops when the FIFO is full.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_last,
    input  logic [3:0]        i_in_opcode,
    input  logic [2:0]        i_in_rd,
    input  logic [2:0]        i_in_rs,
    input  logic [2:0]        i_in_rt,
    input  logic [2:0]        i_in_shamt,
    input  logic [5:0]        i_in_const,
    input  logic [7:0]        i_in_adr,
    output logic              o_mem_we,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wrap_err,
    output logic [ADDR_W-1:0] o_count
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t              r_state;
    state_t              w_next;
    logic                w_session_start;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [15:0]         w_head;
    logic [15:0]         w_word;
    fields_t             w_fields;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_count;
    logic                r_wrap;

    assign w_fields = '{opcode: i_in_opcode, rd: i_in_rd, rs: i_in_rs, rt: i_in_rt,
                        shamt: i_in_shamt, imm: i_in_const, adr: i_in_adr};
    assign w_word   = encode_instr(w_fields);

    assign o_in_ready  = (r_state == ST_RUN) && !w_full;
    assign w_push      = i_in_valid && o_in_ready;
    assign o_mem_we    = !w_empty;
    assign w_pop       = o_mem_we && i_mem_ready;
    assign o_mem_wdata = w_empty ? 16'h0000 : w_head;
    assign o_mem_addr  = r_addr;
    assign o_count     = r_count;
    assign o_wrap_err  = r_wrap;
    assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign o_done      = (r_state == ST_DONE);

    sync_fifo #(
        .W     (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_din   (w_word),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        w_session_start = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_next          = ST_RUN;
                    w_session_start = 1'b1;
                end
            end
            ST_RUN:   if (w_push && i_in_last) w_next = ST_DRAIN;
            ST_DRAIN: if (w_empty) w_next = ST_DONE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // A session only starts with the FIFO empty, so start and pop never coincide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= BASE;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_session_start) begin
            r_addr  <= BASE;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_pop) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count + 1'b1;
            if (r_addr == {ADDR_W{1'b1}}) r_wrap <= 1'b1;
        end
    end

endmodule
